// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks a PC through a combinational-read instruction
// memory and buffers {instruction, pc} pairs in a 2-entry FIFO for decode.
module fetch_unit #(
  parameter int unsigned    N         = 16,
  parameter int unsigned    eff       = 10,
  parameter logic [N-1:0]   RESET_PC  = 16'h0000,
  parameter logic [N-1:0]   HALT_WORD = 16'hFFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_data,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [N-1:0] inst_out,
  output logic [N-1:0] inst_pc,
  output logic         halted,
  output logic [1:0]   dbg_state
);

  // Handshake: the head entry is transferred to decode on a rising edge where
  // inst_valid && inst_ready; inst_valid never depends on inst_ready.

  if (eff > N) begin : g_eff_check
    $error("fetch_unit: eff must not exceed N");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]   count_q, count_d;
  logic [N-1:0] ent_inst_q [2];
  logic [N-1:0] ent_pc_q   [2];
  logic [N-1:0] ent_inst_d [2];
  logic [N-1:0] ent_pc_d   [2];

  logic pop;
  logic push;
  logic flush;
  logic wr_slot;

  assign pop   = inst_valid && inst_ready;
  assign flush = redirect_valid && (state_q != S_IDLE);

  // After an optional pop, the new word lands in the first free slot.
  assign wr_slot = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    ent_inst_d = ent_inst_q;
    ent_pc_d   = ent_pc_q;
    push       = 1'b0;

    if (flush) begin
      // Redirect wins over everything: an accepted head is consumed and dropped.
      count_d    = 2'd0;
      fetch_pc_d = redirect_pc;
      state_d    = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_FETCH;
        end
        S_FETCH: begin
          push = (count_q != 2'd2) || pop;
          if (push && (imem_data == HALT_WORD)) state_d = S_HALT;
        end
        default: ;
      endcase

      if (pop) begin
        ent_inst_d[0] = ent_inst_q[1];
        ent_pc_d[0]   = ent_pc_q[1];
      end

      if (push) begin
        ent_inst_d[wr_slot] = imem_data;
        ent_pc_d[wr_slot]   = fetch_pc_q;
        fetch_pc_d          = fetch_pc_q + N'(1);
      end

      count_d = count_q - 2'(pop) + 2'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed while count is nonzero.
  always_ff @(posedge clk) begin
    ent_inst_q <= ent_inst_d;
    ent_pc_q   <= ent_pc_d;
  end

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst_out   = ent_inst_q[0];
  assign inst_pc    = ent_pc_q[0];
  assign halted     = (state_q == S_HALT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a random
// phase, all cross-checked every cycle against a queue-based reference model.
module tb_fetch_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic [W-1:0] imem_addr;
  logic [W-1:0] imem_data;
  logic         inst_valid;
  logic         inst_ready;
  logic [W-1:0] inst_out;
  logic [W-1:0] inst_pc;
  logic         halted;
  logic [1:0]   dbg_state;

  logic [W-1:0] mem [0:1023];

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:0]];

  fetch_unit #(
    .N(16), .eff(10), .RESET_PC(16'h0000), .HALT_WORD(16'hFFFF)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .halted(halted), .dbg_state(dbg_state)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Mode values match the documented dbg_state encoding: idle 0, fetch 1, halt 2.
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_HALT  = 2;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_pc;
  int             m_mode;
  bit             m_known = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] w;
    if (rst) begin
      exp_q.delete();
      m_pc    = 16'h0000;
      m_mode  = M_IDLE;
      m_known = 1'b1;
    end else if (m_known) begin
      if (redirect_valid && m_mode != M_IDLE) begin
        exp_q.delete();
        m_pc   = redirect_pc;
        m_mode = M_FETCH;
      end else begin
        if (exp_q.size() != 0 && inst_ready) void'(exp_q.pop_front());
        if (m_mode == M_FETCH && exp_q.size() < 2) begin
          w = mem[m_pc[9:0]];
          exp_q.push_back({w, m_pc});
          m_pc = m_pc + 16'd1;
          if (w == 16'hFFFF) m_mode = M_HALT;
        end else if (m_mode == M_IDLE && start) begin
          m_mode = M_FETCH;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_known) begin
      check("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("inst_out", 32'(inst_out), 32'(exp_q[0][2*W-1:W]));
        check("inst_pc", 32'(inst_pc), 32'(exp_q[0][W-1:0]));
      end
      check("halted", 32'(halted), 32'(m_mode == M_HALT));
      check("imem_addr", 32'(imem_addr), 32'(m_pc));
      check("state", 32'(dbg_state), 32'(m_mode));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_head(string name, logic [W-1:0] data, logic [W-1:0] pc);
    check({name, "_valid"}, 32'(inst_valid), 32'd1);
    check({name, "_data"}, 32'(inst_out), 32'(data));
    check({name, "_pc"}, 32'(inst_pc), 32'(pc));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; inst_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[10'h040] = 16'hABCD;
    mem[10'h3FF] = 16'h5A5A;
    tick(); tick();
    rst = 1'b0;

    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h0000);
    check("rst_state", 32'(dbg_state), 32'd0);

    // streaming
    inst_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check("stream_t1_valid", 32'(inst_valid), 32'd0);
    tick(); expect_head("stream0", 16'h1111, 16'h0000);
    tick(); expect_head("stream1", 16'h2222, 16'h0001);
    tick(); expect_head("stream2", 16'h3333, 16'h0002);
    tick(); expect_head("stream3", 16'h4444, 16'h0003);

    // backpressure
    do_reset();
    inst_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    expect_head("bp_hold", 16'h1111, 16'h0000);
    check("bp_addr", 32'(imem_addr), 32'h0002);
    inst_ready = 1'b1;
    tick(); expect_head("bp1", 16'h2222, 16'h0001);
    tick(); expect_head("bp2", 16'h3333, 16'h0002);

    // redirect with a full buffer
    do_reset();
    inst_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    check("rd_full_addr", 32'(imem_addr), 32'h0002);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick(); redirect_valid = 1'b0;
    check("rd_flush_valid", 32'(inst_valid), 32'd0);
    check("rd_addr", 32'(imem_addr), 32'h0040);
    tick(); expect_head("rd_target", 16'hABCD, 16'h0040);

    // halt
    mem[2] = 16'hFFFF;
    do_reset();
    inst_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); expect_head("h0", 16'h1111, 16'h0000);
    tick(); expect_head("h1", 16'h2222, 16'h0001);
    check("h1_halted", 32'(halted), 32'd0);
    tick(); expect_head("h2", 16'hFFFF, 16'h0002);
    check("h2_halted", 32'(halted), 32'd1);
    check("h2_addr", 32'(imem_addr), 32'h0003);
    tick();
    check("h3_valid", 32'(inst_valid), 32'd0);
    check("h3_halted", 32'(halted), 32'd1);
    check("h3_addr", 32'(imem_addr), 32'h0003);
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    tick(); redirect_valid = 1'b0;
    check("h_restart_halted", 32'(halted), 32'd0);
    check("h_restart_state", 32'(dbg_state), 32'd1);
    tick(); expect_head("h_restart", 16'h1111, 16'h0000);

    // wrap
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick(); redirect_valid = 1'b0;
    check("wrap_flush", 32'(inst_valid), 32'd0);
    tick(); expect_head("wrap_hi", 16'h5A5A, 16'hFFFF);
    tick(); expect_head("wrap_lo", 16'h1111, 16'h0000);

    // reset mid-stream with a full buffer
    inst_ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("mrst_valid", 32'(inst_valid), 32'd0);
    check("mrst_halted", 32'(halted), 32'd0);
    check("mrst_addr", 32'(imem_addr), 32'h0000);
    check("mrst_state", 32'(dbg_state), 32'd0);
    inst_ready = 1'b1;
    repeat (3) tick();
    check("mrst_idle_valid", 32'(inst_valid), 32'd0);
    check("mrst_idle_addr", 32'(imem_addr), 32'h0000);

    // random phase
    rst = 1'b1;
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'($urandom);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 199) == 0);
      start          = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                                   : 16'($urandom_range(0, 1023));
      inst_ready     = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0; start = 1'b0; redirect_valid = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
